aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
Two-requester round-robin scheduler and round sequencer for one shared iterative AES encryption round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus an expanded key schedule). It accepts 128-bit plaintext blocks over valid/ready from two clients and owns the state register. It steps the external round logic through rounds 0..Nr and returns the ciphertext, tagged with the requester ID, over a valid/ready response channel. One block is in flight at a time.

Parameters:
Nr, 10, number of AES rounds; legal values 10, 12 and 14 (AES-128/192/256); key schedule holds Nr+1 round keys.
RW, 4, width of round_idx; must satisfy 2^RW > Nr.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a block
req0_ready  output  1  requester 0 block accepted this cycle when high with req0_valid
req0_data  input  128  requester 0 plaintext
req1_valid  input  1  requester 1 has a block
req1_ready  output  1  requester 1 accept strobe, same rules as port 0
req1_data  input  128  requester 1 plaintext
dp_state  output  128  current state register, feeds the round datapath
round_idx  output  RW  round-key index for AddRoundKey (0..Nr)
round_first  output  1  round 0: datapath result = dp_state XOR key[0]
round_last  output  1  round Nr: datapath omits MixColumns
dp_result  input  128  combinational round result from the datapath
resp_valid  output  1  ciphertext available
resp_ready  input  1  consumer accepts response
resp_data  output  128  ciphertext
resp_id  output  1  requester that issued the block

Behaviour:
- Reset (async, immediate): FSM=IDLE, state reg=0, round_idx=0, resp_valid=0, resp_data=0, resp_id=0, last_grant=1 so requester 0 wins the first tie. req*_ready=0 while reset is high.
- FSM states are IDLE, RUN and DONE.
- IDLE, grant selection:
  - Only one valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - reqN_ready = (FSM==IDLE) & grant==N & reqN_valid. This is combinational and at most one ready is high.
- IDLE, on an accept edge:
  - state <= reqN_data, id <= N, last_grant <= N, round_idx <= 0, FSM <= RUN.
- RUN, every cycle:
  - state <= dp_result.
  - If round_idx==Nr, FSM <= DONE and round_idx <= 0. Otherwise round_idx <= round_idx+1.
- round_first = RUN & round_idx==0. round_last = RUN & round_idx==Nr. Both are 0 outside RUN.
- dp_state = state register at all times. round_idx holds 0 outside RUN.
- RUN lasts exactly Nr+1 cycles.
- DONE:
  - resp_valid=1, resp_data=state, resp_id=id.
  - These are held stable until resp_valid & resp_ready.
  - On the handshake edge FSM <= IDLE. No new accept happens in that same cycle.
- Latency and throughput:
  - resp_valid rises Nr+1 cycles after the accept edge (clock edges: accept at T, resp_valid high after edge T+Nr+1).
  - Minimum issue interval is Nr+3 cycles.
- Backpressure: while resp_ready=0, the FSM stays in DONE, both ready outputs stay 0, and requests wait.
- A request that drops valid before being granted is simply not taken. The scheduler imposes no fairness obligation on withdrawn requests.
- Reset mid-RUN or mid-DONE: the block is aborted with no response, and all outputs return to reset values within the same cycle (async).
- Width rules: round_idx compare uses the full RW bits and never wraps, because Nr < 2^RW.

Test Plan:
- Nr=10, round datapath plus key expansion attached, key 000102..0f, req0 sends 00112233445566778899aabbccddeeff, resp_ready=1 -> resp_data 69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0, resp_valid exactly 11 cycles after accept, round_idx sequence 0..10 with round_first at 0 and round_last at 10.
- Nr=12, key 000102..17, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 13. Nr=14, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089, latency 15.
- Both requesters held valid continuously with distinct plaintexts -> grants alternate 0,1,0,1 over 4 blocks, resp_id alternates, each ciphertext matches its own plaintext, and no two ready pulses come closer than Nr+3 cycles.
- Hold resp_ready=0 for 20 cycles after resp_valid -> resp_data and resp_id stable, req0_ready and req1_ready stay 0. Release -> handshake, IDLE on the next cycle, then the next accept.
- Assert reset for 1 cycle at round_idx=5 -> resp_valid never rises for that block, state reg and round_idx read 0 immediately, and req0 is granted first after release even if req1 is also valid.
- Only req1 valid after reset -> req1 accepted on the first cycle, with no waiting for req0.

Source files
------------

// File: rtl/aes_round_sched_if.sv
// Signal bundle between the AES round scheduler, its two requesters, the
// response consumer and the external iterative round datapath.
interface aes_round_sched_if #(
  parameter int RW = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [127:0]   req0_data;
  logic           req1_valid;
  logic           req1_ready;
  logic [127:0]   req1_data;
  logic [127:0]   dp_state;
  logic [RW-1:0]  round_idx;
  logic           round_first;
  logic           round_last;
  logic [127:0]   dp_result;
  logic           resp_valid;
  logic           resp_ready;
  logic [127:0]   resp_data;
  logic           resp_id;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, dp_result, resp_ready,
    output req0_ready, req1_ready, dp_state, round_idx, round_first, round_last,
           resp_valid, resp_data, resp_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, dp_result, resp_ready,
    input  req0_ready, req1_ready, dp_state, round_idx, round_first, round_last,
           resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/aes_round_sched.sv
// Round-robin scheduler and round sequencer sharing one iterative AES round
// datapath between two requesters; one block in flight at a time.
module aes_round_sched #(
  parameter int Nr = 10,
  parameter int RW = 4
) (
  input  logic              clk,
  input  logic              reset,
  aes_round_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  localparam logic [RW-1:0] LastRound = RW'(Nr);

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [RW-1:0] round_idx_q, round_idx_d;
  logic          id_q, id_d;
  logic          last_grant_q, last_grant_d;
  logic          resp_valid_q, resp_valid_d;
  logic          grant;
  logic          ready0;
  logic          ready1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
    ready0 = (fsm_q == IDLE) && !reset && !grant && bus.req0_valid;
    ready1 = (fsm_q == IDLE) && !reset &&  grant && bus.req1_valid;
  end

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    round_idx_d  = round_idx_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    case (fsm_q)
      IDLE: begin
        if (ready0) begin
          state_d      = bus.req0_data;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          round_idx_d  = '0;
          fsm_d        = RUN;
        end else if (ready1) begin
          state_d      = bus.req1_data;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          round_idx_d  = '0;
          fsm_d        = RUN;
        end
      end
      RUN: begin
        state_d = bus.dp_result;
        if (round_idx_q == LastRound) begin
          fsm_d        = DONE;
          round_idx_d  = '0;
          resp_valid_d = 1'b1;
        end else begin
          round_idx_d = round_idx_q + 1'b1;
        end
      end
      DONE: begin
        // The response is held until taken; no accept shares the handshake cycle.
        if (bus.resp_ready) begin
          fsm_d        = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= IDLE;
      state_q      <= '0;
      round_idx_q  <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      round_idx_q  <= round_idx_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.dp_state    = state_q;
  assign bus.round_idx   = round_idx_q;
  assign bus.round_first = (fsm_q == RUN) && (round_idx_q == '0);
  assign bus.round_last  = (fsm_q == RUN) && (round_idx_q == LastRound);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = state_q;
  assign bus.resp_id     = id_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: AES round datapaths for Nr=10/12/14 built around
// three scheduler instances, with a cycle-level model of the Nr=10 scheduler.
module tb_aes_round_sched;

  localparam int NR10 = 10;
  localparam logic [255:0] KEY10 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY12 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY14 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   test_count = 0;
  int   fail_count = 0;

  aes_round_sched_if #(.RW(4)) bus10();
  aes_round_sched_if #(.RW(4)) bus12();
  aes_round_sched_if #(.RW(4)) bus14();

  aes_round_sched #(.Nr(10), .RW(4)) u_dut10 (.clk(clk), .reset(reset), .bus(bus10));
  aes_round_sched #(.Nr(12), .RW(4)) u_dut12 (.clk(clk), .reset(reset), .bus(bus12));
  aes_round_sched #(.Nr(14), .RW(4)) u_dut14 (.clk(clk), .reset(reset), .bus(bus14));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, p, s, t;
    inv = 8'h01; p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, p);
      p = gmul(p, p);
    end
    s = inv; t = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nr, input int r_in);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, r;
    nk = nr - 6; rcon = 8'h01;
    r = (r_in > nr) ? nr : r_in;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i - nk] ^ t;
      end
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                             input logic first, input logic last);
    logic [7:0] b [16];
    logic [7:0] sr [16];
    logic [7:0] o [16];
    logic [127:0] res;
    if (first) return st ^ k;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8 * i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) o[4 * c + r] = sr[4 * c + r];
      end else begin
        o[4*c]   = gmul(sr[4*c], 8'h02) ^ gmul(sr[4*c+1], 8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
        o[4*c+1] = sr[4*c] ^ gmul(sr[4*c+1], 8'h02) ^ gmul(sr[4*c+2], 8'h03) ^ sr[4*c+3];
        o[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul(sr[4*c+2], 8'h02) ^ gmul(sr[4*c+3], 8'h03);
        o[4*c+3] = gmul(sr[4*c], 8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul(sr[4*c+3], 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = o[i];
    return res ^ k;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key, input int nr);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r <= nr; r++) s = aes_round(s, round_key(key, nr, r), r == 0, r == nr);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb bus10.dp_result = aes_round(bus10.dp_state, round_key(KEY10, 10, int'(bus10.round_idx)),
                                          bus10.round_first, bus10.round_last);
  always_comb bus12.dp_result = aes_round(bus12.dp_state, round_key(KEY12, 12, int'(bus12.round_idx)),
                                          bus12.round_first, bus12.round_last);
  always_comb bus14.dp_result = aes_round(bus14.dp_state, round_key(KEY14, 14, int'(bus14.round_idx)),
                                          bus14.round_first, bus14.round_last);

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [127:0] d0, input logic v1,
                               input logic [127:0] d1, input logic rr);
    bus10.req0_valid = v0;
    bus10.req0_data  = d0;
    bus10.req1_valid = v1;
    bus10.req1_data  = d1;
    bus10.resp_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scheduler model for the Nr=10 instance: block timing is derived from the
  // accept edge, grants from the round-robin rule.
  typedef struct {
    logic         id;
    logic [127:0] pt;
    logic [127:0] ct;
    int           acc;
  } blk_t;

  blk_t cur;
  bit   in_flight  = 1'b0;
  bit   model_last = 1'b1;
  int   last_rdy   = -1;
  int   accepts    = 0;
  logic mon_e0, mon_e1, mon_rv;
  int   mon_r;

  always @(posedge reset) begin
    in_flight  = 1'b0;
    model_last = 1'b1;
    last_rdy   = -1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      mon_e0 = !in_flight && bus10.req0_valid && (!bus10.req1_valid || model_last);
      mon_e1 = !in_flight && bus10.req1_valid && (!bus10.req0_valid || !model_last);
      checkOutput("req0_ready", 128'(bus10.req0_ready), 128'(mon_e0));
      checkOutput("req1_ready", 128'(bus10.req1_ready), 128'(mon_e1));
      mon_r = cyc - cur.acc;
      if (in_flight && mon_r <= NR10) begin
        checkOutput("round_idx", 128'(bus10.round_idx), 128'(mon_r));
        checkOutput("round_first", 128'(bus10.round_first), 128'(mon_r == 0));
        checkOutput("round_last", 128'(bus10.round_last), 128'(mon_r == NR10));
        if (mon_r == 0) checkOutput("dp_state_load", bus10.dp_state, cur.pt);
      end else begin
        checkOutput("round_idx_idle", 128'(bus10.round_idx), 128'(0));
        checkOutput("round_flags_idle", 128'({bus10.round_first, bus10.round_last}), 128'(0));
      end
      mon_rv = in_flight && mon_r > NR10;
      checkOutput("resp_valid", 128'(bus10.resp_valid), 128'(mon_rv));
      if (mon_rv) begin
        checkOutput("resp_data", bus10.resp_data, cur.ct);
        checkOutput("resp_id", 128'(bus10.resp_id), 128'(cur.id));
      end
      if (mon_rv && bus10.resp_ready) begin
        in_flight = 1'b0;
      end else if (mon_e0 || mon_e1) begin
        cur.id  = mon_e1;
        cur.pt  = mon_e1 ? bus10.req1_data : bus10.req0_data;
        cur.ct  = aes_encrypt(cur.pt, KEY10, NR10);
        cur.acc = cyc + 1;
        if (last_rdy >= 0) checkOutput("issue_gap", 128'((cyc - last_rdy) >= NR10 + 3), 128'(1));
        last_rdy   = cyc;
        model_last = mon_e1;
        in_flight  = 1'b1;
        accepts++;
      end
    end
  end

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (!in_flight) return;
      tick();
    end
    checkOutput({tag, "_timeout"}, 128'(0), 128'(1));
  endtask

  int n0;
  int lat12, lat14;
  bit seen;

  initial begin
    bus12.req0_valid = 1'b0; bus12.req0_data = '0; bus12.req1_valid = 1'b0;
    bus12.req1_data  = '0;   bus12.resp_ready = 1'b1;
    bus14.req0_valid = 1'b0; bus14.req0_data = '0; bus14.req1_valid = 1'b0;
    bus14.req1_data  = '0;   bus14.resp_ready = 1'b1;
    applyStimulus(1'b1, rand128(), 1'b1, rand128(), 1'b1);
    #2;
    checkOutput("rst_req0_ready", 128'(bus10.req0_ready), 128'(0));
    checkOutput("rst_req1_ready", 128'(bus10.req1_ready), 128'(0));
    checkOutput("rst_resp_valid", 128'(bus10.resp_valid), 128'(0));
    checkOutput("rst_dp_state", bus10.dp_state, 128'(0));
    checkOutput("rst_resp_data", bus10.resp_data, 128'(0));
    checkOutput("rst_resp_id", 128'(bus10.resp_id), 128'(0));
    checkOutput("rst_round_idx", 128'(bus10.round_idx), 128'(0));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // Lone requester 1 is taken immediately.
    tick();
    applyStimulus(1'b0, '0, 1'b1, rand128(), 1'b1);
    #1 checkOutput("req1_only_ready", 128'(bus10.req1_ready), 128'(1));
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    waitIdle("req1_only");

    // Known-answer block from requester 0.
    tick();
    applyStimulus(1'b1, PT_KAT, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus10.resp_valid) begin
        seen = 1'b1;
        checkOutput("kat10_ct", bus10.resp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checkOutput("kat10_id", 128'(bus10.resp_id), 128'(0));
      end else begin
        tick();
      end
    end
    if (!seen) checkOutput("kat10_timeout", 128'(0), 128'(1));
    waitIdle("kat10");

    // Both requesters held valid: four alternating grants.
    n0 = accepts;
    for (int i = 0; i < 120 && accepts < n0 + 4; i++) begin
      tick();
      applyStimulus(1'b1, rand128(), 1'b1, rand128(), 1'b1);
    end
    if (accepts < n0 + 4) checkOutput("alternate_timeout", 128'(0), 128'(1));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    waitIdle("alternate");

    // Backpressure for 20 cycles with both requests pending.
    tick();
    applyStimulus(1'b1, rand128(), 1'b1, rand128(), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = bus10.resp_valid;
    end
    if (!seen) checkOutput("bp_timeout", 128'(0), 128'(1));
    repeat (20) tick();
    applyStimulus(1'b1, bus10.req0_data, 1'b1, bus10.req1_data, 1'b1);
    tick();
    checkOutput("bp_release_accept", 128'(bus10.req0_ready | bus10.req1_ready), 128'(1));
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    waitIdle("backpressure");

    // Random traffic with withdrawn requests and random response stalls.
    for (int i = 0; i < 600; i++) begin
      tick();
      applyStimulus(($urandom % 3) != 0, rand128(), ($urandom % 3) != 0, rand128(), ($urandom % 4) != 0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    waitIdle("random");

    // Reset in the middle of round 5 aborts the block.
    tick();
    applyStimulus(1'b1, rand128(), 1'b1, rand128(), 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (bus10.round_idx == 4'd5);
    end
    if (!seen) checkOutput("mid_reset_timeout", 128'(0), 128'(1));
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_reset_dp_state", bus10.dp_state, 128'(0));
    checkOutput("mid_reset_round_idx", 128'(bus10.round_idx), 128'(0));
    checkOutput("mid_reset_resp_valid", 128'(bus10.resp_valid), 128'(0));
    checkOutput("mid_reset_ready", 128'({bus10.req0_ready, bus10.req1_ready}), 128'(0));
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("post_reset_req0", 128'(bus10.req0_ready), 128'(1));
    checkOutput("post_reset_req1", 128'(bus10.req1_ready), 128'(0));
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    waitIdle("post_reset");

    // Known answers and latency for AES-192 and AES-256 schedules.
    tick();
    bus12.req0_valid = 1'b1; bus12.req0_data = PT_KAT;
    bus14.req0_valid = 1'b1; bus14.req0_data = PT_KAT;
    #1;
    checkOutput("kat12_ready", 128'(bus12.req0_ready), 128'(1));
    checkOutput("kat14_ready", 128'(bus14.req0_ready), 128'(1));
    tick();
    bus12.req0_valid = 1'b0;
    bus14.req0_valid = 1'b0;
    lat12 = -1; lat14 = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus12.resp_valid && lat12 < 0) begin
        lat12 = n - 1;
        checkOutput("kat12_ct", bus12.resp_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      end
      if (bus14.resp_valid && lat14 < 0) begin
        lat14 = n - 1;
        checkOutput("kat14_ct", bus14.resp_data, 128'h8ea2b7ca516745bfeafc49904b496089);
      end
    end
    checkOutput("kat12_latency", 128'(lat12), 128'(13));
    checkOutput("kat14_latency", 128'(lat14), 128'(15));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
